otter_cu_fsm: RTL and testbench
===============================

Name: otter_cu_fsm

Overview:
- Multicycle sequencer for the OTTER RV32I core.
- Steps each instruction through fetch, execute and optional writeback, and waits on memory acknowledgements.
- Holds the datapath in reset during initialisation and inserts the interrupt-entry cycle.
- Drives all write enables and memory strobes. Its int_taken output feeds the combinational decoder, which forces PC_SEL to the ISR address.

Parameters:
- INIT_CYCLES, 2, number of cycles rst_dp stays high after RST_N deasserts (legal range 1..15).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- opcode  in  7  ir[6:0].
- func3  in  3  ir[14:12].
- intr  in  1  external interrupt request, level, already synchronised.
- csr_mie  in  1  global interrupt enable (mstatus.MIE).
- imem_ack  in  1  instruction read data valid this cycle.
- dmem_ack  in  1  data read/write complete this cycle.
- PC_WE  out  1  PC register write enable.
- RF_WE  out  1  register file write enable.
- memRDEN1  out  1  instruction memory read strobe.
- memRDEN2  out  1  data memory read strobe.
- memWE2  out  1  data memory write strobe.
- csr_WE  out  1  CSR file write enable.
- int_taken  out  1  interrupt entry cycle; also drives the decoder.
- mret_exec  out  1  MRET retiring; CSR file restores MIE.
- rst_dp  out  1  datapath reset (PC, CSRs).
- fsm_state  out  3  current state encoding, for debug and verification.

Behaviour:
- Outputs are combinational from state plus the decoded inputs (Moore/Mealy mix). All outputs are 0 unless listed.
- Reset: RST_N=0 sampled at a CLK edge gives state<=ST_INIT and init_cnt<=0. The reset is honoured from any state, including mid-fetch or mid-store. In-flight memory strobes drop the next cycle, with no write completion.
- States (3-bit encoding): ST_INIT=0, ST_FETCH=1, ST_EXEC=2, ST_WB=3, ST_INTR=4. Codes 5..7 are illegal and go to ST_INIT.
- ST_INIT:
  - rst_dp=1; init_cnt increments.
  - When init_cnt==INIT_CYCLES-1, next state is ST_FETCH. rst_dp therefore stays high for exactly INIT_CYCLES cycles after reset release.
- ST_FETCH:
  - memRDEN1=1.
  - imem_ack=0: stay in ST_FETCH.
  - imem_ack=1: go to ST_EXEC; IR latches externally on the same edge.
  - Fetch latency is 1 cycle plus the number of wait cycles.
- ST_EXEC, decoded by opcode:
  - LOAD (0000011): memRDEN2=1, then ST_WB. No PC_WE in this state.
  - STORE (0100011): memWE2=1 held while dmem_ack=0 (stay in ST_EXEC). In the dmem_ack=1 cycle, PC_WE=1, then exit.
  - BRANCH (1100011): PC_WE=1, RF_WE=0.
  - SYS (1110011), func3=000: PC_WE=1, mret_exec=1.
  - SYS, func3 in {001,010,011}: PC_WE=1, RF_WE=1, csr_WE=1.
  - SYS, any other func3: PC_WE=1, RF_WE=1, csr_WE=0.
  - LUI, AUIPC, JAL, JALR, OP_IMM, OP: PC_WE=1, RF_WE=1.
  - Unknown opcode: treated as a NOP; PC_WE=1 only.
- ST_WB:
  - memRDEN2=1 held while dmem_ack=0.
  - In the dmem_ack=1 cycle: RF_WE=1 and PC_WE=1, then exit.
- Exit rule for ST_EXEC (instruction complete) and ST_WB:
  - pend = intr & csr_mie.
  - pend=1: next state is ST_INTR.
  - pend=0: next state is ST_FETCH.
  - An interrupt is never taken mid-instruction, i.e. not while waiting on dmem_ack.
  - MRET exit also samples pend. csr_mie is the pre-MRET value, so a pending interrupt may be taken immediately only if MIE was already 1.
- ST_INTR:
  - int_taken=1, PC_WE=1; next state is ST_FETCH unconditionally.
  - intr is ignored in ST_INTR. csr_mie clearing is done externally by the CSR file on int_taken.
- Simultaneous events:
  - RST_N=0 has priority over every transition.
  - imem_ack in a non-FETCH state and dmem_ack outside LOAD/STORE waits are ignored.
- Invariants:
  - At most one of memRDEN1, memRDEN2, memWE2 is high per cycle.
  - PC_WE is high exactly once per retired instruction, plus once per ST_INTR.

Decomposition:
- otter_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_RG3, INTR);
  - cu_state_t enum (3-bit, values above);
  - SYS func3 constants: F3_MRET=000, F3_CSRRW=001, F3_CSRRS=010, F3_CSRRC=011.
- No sub-module; single module with a state register, init_cnt, and one always_comb output/next-state block.

Test Plan:
- Reset, INIT_CYCLES=2:
  - RST_N low 3 cycles then high → rst_dp=1 for 2 cycles, fsm_state 0,0,1.
  - memRDEN1=1 on the first ST_FETCH cycle.
- ADDI (opcode 0010011), imem_ack after 2 wait cycles → FETCH for 3 cycles, then 1 EXEC cycle with PC_WE=1 and RF_WE=1, then FETCH.
- LW (0000011) with dmem_ack delayed 3 cycles → EXEC memRDEN2=1, then WB holds memRDEN2 for 4 cycles. RF_WE=1 and PC_WE=1 only in the final cycle.
- SW (0100011) with RST_N pulled low during the dmem_ack wait → next cycle fsm_state=0 and memWE2=0. No PC_WE was ever asserted.
- intr=1, csr_mie=1 during BEQ EXEC → next state ST_INTR with int_taken=1 and PC_WE=1, then FETCH. Repeat with csr_mie=0 → no ST_INTR.
- SYS func3=011 → csr_WE=1, RF_WE=1, PC_WE=1. SYS func3=000 → mret_exec=1, RF_WE=0.

Source files
------------

// File: rtl/otter_pkg.sv
// ---------------------------------------------------------------------------
// otter_pkg
// Shared encodings for the OTTER RV32I control unit:
//   opcode_t   - RV32I major opcodes (ir[6:0]); INTR is the SYSTEM opcode
//   cu_state_t - 3-bit sequencer state encoding
//   F3_*       - SYSTEM-opcode func3 values the sequencer distinguishes
// ---------------------------------------------------------------------------
package otter_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    INTR   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    CU_INIT  = 3'd0,
    CU_FETCH = 3'd1,
    CU_EXEC  = 3'd2,
    CU_WB    = 3'd3,
    CU_INTR  = 3'd4
  } cu_state_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

endpackage

// File: rtl/otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// otter_cu_fsm
// Multicycle sequencer for the OTTER RV32I core. Steps each instruction
// through fetch, execute and optional writeback, waits on memory acks,
// holds the datapath in reset for INIT_CYCLES after reset release, and
// inserts an interrupt-entry cycle between instructions.
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   opcode, func3     instruction fields from the IR
//   intr, csr_mie     interrupt request and global enable
//   imem_ack/dmem_ack memory completion handshakes
//   PC_WE, RF_WE, csr_WE            datapath write enables
//   memRDEN1, memRDEN2, memWE2      memory strobes
//   int_taken, mret_exec, rst_dp    control side-effects
//   fsm_state                       current state code (debug)
// ---------------------------------------------------------------------------
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int INIT_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  input  logic       csr_mie,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       PC_WE,
  output logic       RF_WE,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       memWE2,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       rst_dp,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] ST_INIT  = CU_INIT;
  localparam logic [2:0] ST_FETCH = CU_FETCH;
  localparam logic [2:0] ST_EXEC  = CU_EXEC;
  localparam logic [2:0] ST_WB    = CU_WB;
  localparam logic [2:0] ST_INTR  = CU_INTR;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  logic [2:0] state_r;
  logic [2:0] next_state_s;
  logic [3:0] init_cnt_r;
  logic [3:0] init_cnt_next_s;
  logic       pend_s;
  logic [2:0] exit_state_s;

  // Interrupts are only sampled at an instruction boundary.
  assign pend_s       = intr & csr_mie;
  assign exit_state_s = pend_s ? ST_INTR : ST_FETCH;
  assign fsm_state    = state_r;

  // Next-state and output decode from current state plus decoded inputs.
  always_comb begin
    next_state_s    = state_r;
    init_cnt_next_s = 4'd0;
    PC_WE           = 1'b0;
    RF_WE           = 1'b0;
    memRDEN1        = 1'b0;
    memRDEN2        = 1'b0;
    memWE2          = 1'b0;
    csr_WE          = 1'b0;
    int_taken       = 1'b0;
    mret_exec       = 1'b0;
    rst_dp          = 1'b0;

    case (state_r)
      ST_INIT: begin
        rst_dp = 1'b1;
        if (init_cnt_r == INIT_LAST) begin
          next_state_s    = ST_FETCH;
          init_cnt_next_s = 4'd0;
        end else begin
          next_state_s    = ST_INIT;
          init_cnt_next_s = init_cnt_r + 4'd1;
        end
      end

      ST_FETCH: begin
        memRDEN1 = 1'b1;
        if (imem_ack) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (opcode)
          LOAD: begin
            // Read issued here; retirement happens in writeback.
            memRDEN2     = 1'b1;
            next_state_s = ST_WB;
          end
          STORE: begin
            // Strobe held until the write completes; retire on the ack.
            memWE2 = 1'b1;
            if (dmem_ack) begin
              PC_WE        = 1'b1;
              next_state_s = exit_state_s;
            end else begin
              next_state_s = ST_EXEC;
            end
          end
          BRANCH: begin
            PC_WE        = 1'b1;
            next_state_s = exit_state_s;
          end
          INTR: begin
            PC_WE = 1'b1;
            case (func3)
              F3_MRET: begin
                mret_exec = 1'b1;
              end
              F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                RF_WE  = 1'b1;
                csr_WE = 1'b1;
              end
              default: begin
                RF_WE = 1'b1;
              end
            endcase
            next_state_s = exit_state_s;
          end
          LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
            PC_WE        = 1'b1;
            RF_WE        = 1'b1;
            next_state_s = exit_state_s;
          end
          default: begin
            // Unknown opcode retires as a NOP.
            PC_WE        = 1'b1;
            next_state_s = exit_state_s;
          end
        endcase
      end

      ST_WB: begin
        memRDEN2 = 1'b1;
        if (dmem_ack) begin
          RF_WE        = 1'b1;
          PC_WE        = 1'b1;
          next_state_s = exit_state_s;
        end else begin
          next_state_s = ST_WB;
        end
      end

      ST_INTR: begin
        int_taken    = 1'b1;
        PC_WE        = 1'b1;
        next_state_s = ST_FETCH;
      end

      default: begin
        // Illegal codes recover through a full init sequence.
        next_state_s = ST_INIT;
      end
    endcase
  end

  // State and init counter register; reset wins over every transition.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 4'd0;
    end else begin
      state_r    <= next_state_s;
      init_cnt_r <= init_cnt_next_s;
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// ---------------------------------------------------------------------------
// tb_otter_cu_fsm
// Directed self-checking bench for otter_cu_fsm (INIT_CYCLES=2). Inputs
// change on the falling edge; state and all outputs are checked 1 time unit
// later against hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_otter_cu_fsm;

  logic       CLK;
  logic       RST_N;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       intr;
  logic       csr_mie;
  logic       imem_ack;
  logic       dmem_ack;
  logic       PC_WE;
  logic       RF_WE;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       memWE2;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;
  logic       rst_dp;
  logic [2:0] fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Output bundle bit positions: {PC,RF,RD1,RD2,WE2,CSR,INT,MRET,RSTDP}
  localparam logic [8:0] O_NONE = 9'h000;
  localparam logic [8:0] O_PC   = 9'h100;
  localparam logic [8:0] O_RF   = 9'h080;
  localparam logic [8:0] O_RD1  = 9'h040;
  localparam logic [8:0] O_RD2  = 9'h020;
  localparam logic [8:0] O_WE2  = 9'h010;
  localparam logic [8:0] O_CSR  = 9'h008;
  localparam logic [8:0] O_INT  = 9'h004;
  localparam logic [8:0] O_MRET = 9'h002;
  localparam logic [8:0] O_RST  = 9'h001;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_INTR  = 3'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;
  localparam logic [6:0] OPC_BAD    = 7'b0000000;

  otter_cu_fsm #(.INIT_CYCLES(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .opcode    (opcode),
    .func3     (func3),
    .intr      (intr),
    .csr_mie   (csr_mie),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .PC_WE     (PC_WE),
    .RF_WE     (RF_WE),
    .memRDEN1  (memRDEN1),
    .memRDEN2  (memRDEN2),
    .memWE2    (memWE2),
    .csr_WE    (csr_WE),
    .int_taken (int_taken),
    .mret_exec (mret_exec),
    .rst_dp    (rst_dp),
    .fsm_state (fsm_state)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check one cycle's state and outputs, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [8:0] eo);
    logic [8:0] outs;
    #1;
    outs = {PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec, rst_dp};
    check({tag, ".state"}, 32'(fsm_state), 32'(es));
    check({tag, ".outs"}, 32'(outs), 32'(eo));
    @(negedge CLK);
  endtask

  // Fetch with n_wait wait cycles, then present the instruction for EXEC.
  task automatic fetch(input string tag, input int n_wait, input logic [6:0] op, input logic [2:0] f3);
    imem_ack = 1'b0;
    for (int i = 0; i < n_wait; i++) cyc({tag, ".fwait"}, S_FETCH, O_RD1);
    imem_ack = 1'b1;
    cyc({tag, ".fack"}, S_FETCH, O_RD1);
    imem_ack = 1'b0;
    opcode   = op;
    func3    = f3;
  endtask

  initial begin
    RST_N    = 1'b0;
    opcode   = 7'd0;
    func3    = 3'd0;
    intr     = 1'b0;
    csr_mie  = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge CLK);

    // Reset held, then release: rst_dp for exactly 2 cycles.
    for (int i = 0; i < 3; i++) cyc("rst_hold", S_INIT, O_RST);
    RST_N = 1'b1;
    cyc("init0", S_INIT, O_RST);
    cyc("init1", S_INIT, O_RST);

    // ADDI with two fetch wait cycles (first cycle is the first FETCH).
    fetch("addi", 2, OPC_OPIMM, 3'b000);
    cyc("addi.exec", S_EXEC, O_PC | O_RF);

    // LW with dmem_ack arriving on the 4th writeback cycle.
    fetch("lw", 0, OPC_LOAD, 3'b010);
    cyc("lw.exec", S_EXEC, O_RD2);
    for (int i = 0; i < 3; i++) cyc("lw.wbwait", S_WB, O_RD2);
    dmem_ack = 1'b1;
    cyc("lw.wback", S_WB, O_RD2 | O_RF | O_PC);
    dmem_ack = 1'b0;

    // SW completing normally after one wait cycle.
    fetch("sw", 0, OPC_STORE, 3'b010);
    cyc("sw.wait", S_EXEC, O_WE2);
    dmem_ack = 1'b1;
    cyc("sw.ack", S_EXEC, O_WE2 | O_PC);
    dmem_ack = 1'b0;

    // BEQ with pending enabled interrupt -> ST_INTR, then FETCH.
    fetch("beq_int", 0, OPC_BRANCH, 3'b000);
    intr    = 1'b1;
    csr_mie = 1'b1;
    cyc("beq_int.exec", S_EXEC, O_PC);
    cyc("beq_int.intr", S_INTR, O_INT | O_PC);

    // Same with interrupts masked: no ST_INTR.
    fetch("beq_mask", 0, OPC_BRANCH, 3'b000);
    csr_mie = 1'b0;
    cyc("beq_mask.exec", S_EXEC, O_PC);
    intr = 1'b0;

    // CSRRC, MRET, other SYS func3, unknown opcode.
    fetch("csrrc", 0, OPC_SYS, 3'b011);
    cyc("csrrc.exec", S_EXEC, O_PC | O_RF | O_CSR);
    fetch("mret", 0, OPC_SYS, 3'b000);
    cyc("mret.exec", S_EXEC, O_PC | O_MRET);
    fetch("sys100", 0, OPC_SYS, 3'b100);
    cyc("sys100.exec", S_EXEC, O_PC | O_RF);
    fetch("nop", 0, OPC_BAD, 3'b000);
    cyc("nop.exec", S_EXEC, O_PC);

    // Interrupt pending while a store waits: not taken until it retires.
    fetch("sw_int", 0, OPC_STORE, 3'b010);
    intr    = 1'b1;
    csr_mie = 1'b1;
    cyc("sw_int.wait", S_EXEC, O_WE2);
    dmem_ack = 1'b1;
    cyc("sw_int.ack", S_EXEC, O_WE2 | O_PC);
    dmem_ack = 1'b0;
    intr     = 1'b0;
    csr_mie  = 1'b0;
    cyc("sw_int.intr", S_INTR, O_INT | O_PC);

    // SW aborted by reset during the ack wait: strobe drops, no PC_WE.
    fetch("sw_rst", 0, OPC_STORE, 3'b010);
    cyc("sw_rst.wait", S_EXEC, O_WE2);
    RST_N = 1'b0;
    cyc("sw_rst.edge", S_EXEC, O_WE2);
    RST_N = 1'b1;
    cyc("sw_rst.init0", S_INIT, O_RST);
    cyc("sw_rst.init1", S_INIT, O_RST);
    cyc("sw_rst.fetch", S_FETCH, O_RD1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
